// File: rtl/multiplier_sequential.sv
// ============================================================================
// Module   : multiplier_sequential
// Brief    : Shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned,
//            one multiplier bit retired per clock with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier_sequential #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     r_acc;
    logic                   r_sign;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_accept;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [2*WIDTH-1:0]     w_addend;

    // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), still representable unsigned.
    assign w_a_mag  = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign w_b_mag  = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    assign w_addend = {{WIDTH{1'b0}}, r_mcand} << r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == c_LAST) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_sign    <= 1'b0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mcand  <= w_a_mag;
                r_mplier <= w_b_mag;
                r_sign   <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                r_count  <= '0;
                r_acc    <= '0;
            end else if (r_state == S_CALC) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + w_addend;
                end
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + c_CNT_W'(1);
            end else if (r_state == S_FINISH) begin
                r_product <= r_sign ? -r_acc : r_acc;
                r_done    <= 1'b1;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_multiplier_sequential.sv
// ============================================================================
// Module   : tb_multiplier_sequential
// Brief    : Self-checking bench for multiplier_sequential (WIDTH=4), directed
//            cases plus randomized operands against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier_sequential;

    localparam int W = 4;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             signed_mode;
    logic [W-1:0]     multiplicand;
    logic [W-1:0]     multiplier;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int checks   = 0;
    int failures = 0;

    multiplier_sequential #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sm);
        longint sa;
        longint sb;
        sa = sm ? longint'($signed(a)) : longint'(a);
        sb = sm ? longint'($signed(b)) : longint'(b);
        return (2*W)'(sa * sb);
    endfunction

    // Called at a falling edge: present a request for the next rising edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        signed_mode  = sm;
    endtask

    // Follows one accepted request to its done cycle; returns at that cycle's falling edge.
    task automatic finish_op(input logic [2*W-1:0] exp, input string tag, input bit inject);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check({tag, "_busy0"}, {busy, done}, 2'b10);
        for (int k = 1; k <= W; k++) begin
            @(negedge clock);
            if (inject && k == 1) begin
                start        = 1'b1;
                multiplicand = 4'd1;
                multiplier   = 4'd1;
                signed_mode  = 1'($urandom_range(0, 1));
            end
            if (inject && k == 2) start = 1'b0;
            check({tag, "_busy"}, {busy, done}, 2'b10);
        end
        @(negedge clock);
        check({tag, "_done"}, {busy, done}, 2'b01);
        check({tag, "_prod"}, product, exp);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sm;
        bit           saw_done;

        reset_n      = 1'b0;
        start        = 1'b0;
        signed_mode  = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        check("reset_out", {busy, done, product}, '0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        launch(4'd3, 4'd5, 1'b0);
        finish_op(8'h0F, "u3x5", 1'b0);
        @(negedge clock);
        check("done_fall", {busy, done}, 2'b00);
        check("prod_hold", product, 8'h0F);

        launch(4'hF, 4'hF, 1'b0);
        finish_op(8'hE1, "u15x15", 1'b0);
        launch(4'hF, 4'hF, 1'b1);
        finish_op(8'h01, "s_m1xm1", 1'b0);
        launch(4'hD, 4'h5, 1'b1);
        finish_op(8'hF1, "s_m3x5", 1'b0);
        launch(4'h8, 4'h8, 1'b1);
        finish_op(8'h40, "s_m8xm8", 1'b0);
        launch(4'h8, 4'h7, 1'b1);
        finish_op(8'hC8, "s_m8x7", 1'b0);

        // Zero operand then a back-to-back request raised during the done cycle.
        @(negedge clock);
        launch(4'd0, 4'd9, 1'b0);
        finish_op(8'h00, "u0x9", 1'b0);
        launch(4'd2, 4'd6, 1'b0);
        finish_op(8'h0C, "b2b_2x6", 1'b0);

        @(negedge clock);
        launch(4'd7, 4'd7, 1'b0);
        finish_op(8'h31, "ign_7x7", 1'b1);
        @(negedge clock);
        check("ign_no_extra", {busy, done}, 2'b00);

        // Asynchronous reset in the middle of the third busy cycle.
        launch(4'd6, 4'd6, 1'b0);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst", {busy, done, product}, '0);
        @(negedge clock);
        reset_n  = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clock);
            if (done || busy) saw_done = 1'b1;
        end
        check("rst_no_done", saw_done, 1'b0);
        check("rst_prod", product, 8'h00);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clock);
            a  = W'($urandom);
            b  = W'($urandom);
            sm = 1'($urandom_range(0, 1));
            launch(a, b, sm);
            finish_op(ref_mul(a, b, sm), "rand", ($urandom_range(0, 3) == 0));
        end
        @(negedge clock);
        check("final_idle", {busy, done}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
